// File: rtl/biriscv_fetch_queue.sv
// Fetch-to-issue instruction queue: unpacks fetch beats into per-instruction
// entries in a circular buffer and presents up to ISSUE_WIDTH in-order lanes.
module biriscv_fetch_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int DEPTH_W     = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_accept_o,
    input  logic [32*FETCH_WIDTH-1:0]  fetch_instr_i,
    input  logic [31:0]                fetch_pc_i,
    input  logic [FETCH_WIDTH-1:0]     fetch_pred_branch_i,
    input  logic                       fetch_fault_fetch_i,
    input  logic                       fetch_fault_page_i,
    output logic [ISSUE_WIDTH-1:0]     out_valid_o,
    output logic [32*ISSUE_WIDTH-1:0]  out_instr_o,
    output logic [32*ISSUE_WIDTH-1:0]  out_pc_o,
    output logic [ISSUE_WIDTH-1:0]     out_fault_fetch_o,
    output logic [ISSUE_WIDTH-1:0]     out_fault_page_o,
    output logic [ISSUE_WIDTH-1:0]     out_pred_branch_o,
    input  logic [ISSUE_WIDTH-1:0]     out_accept_i,
    output logic [DEPTH_W:0]           level_o
);
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int CNT_W  = DEPTH_W + 1;

    logic [31:0]        mem_instr [DEPTH];
    logic [31:0]        mem_pc    [DEPTH];
    logic [DEPTH-1:0]   mem_fault_fetch;
    logic [DEPTH-1:0]   mem_fault_page;
    logic [DEPTH-1:0]   mem_pred;

    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   n_push;
    logic [CNT_W-1:0]   n_pop;
    logic [SLOT_W-1:0]  start_slot;
    logic [31:0]        pc_base;
    logic               is_fault;
    logic               push;

    logic [31:0]            ent_instr [FETCH_WIDTH];
    logic [31:0]            ent_pc    [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] ent_pred;

    generate
        if (FETCH_WIDTH > 1) begin : g_slot
            assign start_slot = fetch_pc_i[SLOT_W+1:2];
        end else begin : g_slot_single
            assign start_slot = '0;
        end
    endgenerate

    assign pc_base        = fetch_pc_i & ~32'(FETCH_WIDTH*4 - 1);
    assign is_fault       = fetch_fault_fetch_i | fetch_fault_page_i;
    assign fetch_accept_o = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign push           = fetch_valid_i & fetch_accept_o & ~flush_i;
    assign level_o        = count;

    // Kept slots are contiguous from start_slot, so entry j is slot start_slot+j.
    always_comb begin
        logic stop;
        logic [SLOT_W-1:0] slot;
        stop   = 1'b0;
        n_push = '0;
        slot   = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (!stop && (k >= int'(start_slot))) begin
                n_push = n_push + CNT_W'(1);
                stop   = fetch_pred_branch_i[k];
            end
        end
        if (is_fault)
            n_push = CNT_W'(1);
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            slot         = start_slot + SLOT_W'(j);
            ent_instr[j] = is_fault ? 32'h0 : fetch_instr_i[32*slot +: 32];
            ent_pc[j]    = pc_base | {{(30-SLOT_W){1'b0}}, slot, 2'b00};
            ent_pred[j]  = is_fault ? 1'b0 : fetch_pred_branch_i[slot];
        end
    end

    always_comb begin
        logic [DEPTH_W-1:0] idx;
        out_valid_o       = '0;
        out_instr_o       = '0;
        out_pc_o          = '0;
        out_fault_fetch_o = '0;
        out_fault_page_o  = '0;
        out_pred_branch_o = '0;
        idx               = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            idx                     = rd_ptr + DEPTH_W'(k);
            out_valid_o[k]          = (CNT_W'(k) < count) && !flush_i;
            out_instr_o[32*k +: 32] = mem_instr[idx];
            out_pc_o[32*k +: 32]    = mem_pc[idx];
            out_fault_fetch_o[k]    = mem_fault_fetch[idx];
            out_fault_page_o[k]     = mem_fault_page[idx];
            out_pred_branch_o[k]    = mem_pred[idx];
        end
    end

    // Only an unbroken run of accepted lanes from lane 0 is consumed.
    always_comb begin
        logic run;
        run   = 1'b1;
        n_pop = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            run = run & out_valid_o[k] & out_accept_i[k];
            if (run)
                n_pop = n_pop + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + DEPTH_W'(n_pop);
            if (push)
                wr_ptr <= wr_ptr + DEPTH_W'(n_push);
            count <= count + (push ? n_push : CNT_W'(0)) - n_pop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (CNT_W'(j) < n_push) begin
                    mem_instr[wr_ptr + DEPTH_W'(j)]       <= ent_instr[j];
                    mem_pc[wr_ptr + DEPTH_W'(j)]          <= ent_pc[j];
                    mem_fault_fetch[wr_ptr + DEPTH_W'(j)] <= fetch_fault_fetch_i;
                    mem_fault_page[wr_ptr + DEPTH_W'(j)]  <= fetch_fault_page_i;
                    mem_pred[wr_ptr + DEPTH_W'(j)]        <= ent_pred[j];
                end
            end
        end
    end
endmodule
